// File: rtl/alu_issuer_pkg.sv
// Shared constants for the ALU issuer: default widths and ALU opcodes.
package alu_issuer_pkg;

   localparam int unsigned INT_W_DEF     = 3;
   localparam int unsigned FRAC_W_DEF    = 5;
   localparam int unsigned INST_W_DEF    = 3;
   localparam int unsigned CMD_DEPTH_DEF = 4;
   localparam int unsigned TAG_W_DEF     = 4;
   localparam int unsigned CNT_W_DEF     = 8;

   localparam logic [INST_W_DEF-1:0] OP_ADD  = 3'd0;
   localparam logic [INST_W_DEF-1:0] OP_SUB  = 3'd1;
   localparam logic [INST_W_DEF-1:0] OP_MUL  = 3'd2;
   localparam logic [INST_W_DEF-1:0] OP_OR   = 3'd3;
   localparam logic [INST_W_DEF-1:0] OP_XOR  = 3'd4;
   localparam logic [INST_W_DEF-1:0] OP_RELU = 3'd5;
   localparam logic [INST_W_DEF-1:0] OP_MEAN = 3'd6;
   localparam logic [INST_W_DEF-1:0] OP_MIN  = 3'd7;

endpackage

// File: rtl/alu_issuer_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module alu_issuer_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Storage needs no reset; occupancy decides what is visible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_issuer.sv
// Buffers host commands, issues them one per cycle to a 1-cycle ALU and
// returns tagged results in order, counting overflowed results.
module alu_issuer
   import alu_issuer_pkg::*;
#(
   parameter int unsigned INT_W     = INT_W_DEF,
   parameter int unsigned FRAC_W    = FRAC_W_DEF,
   parameter int unsigned INST_W    = INST_W_DEF,
   parameter int unsigned DATA_W    = INT_W + FRAC_W,
   parameter int unsigned CMD_DEPTH = CMD_DEPTH_DEF,
   parameter int unsigned TAG_W     = TAG_W_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [INST_W-1:0] i_cmd_inst,
   input  logic [DATA_W-1:0] i_cmd_a,
   input  logic [DATA_W-1:0] i_cmd_b,
   output logic              o_alu_valid,
   output logic [INST_W-1:0] o_alu_inst,
   output logic [DATA_W-1:0] o_alu_data_a,
   output logic [DATA_W-1:0] o_alu_data_b,
   input  logic              i_alu_valid,
   input  logic [DATA_W-1:0] i_alu_data,
   input  logic              i_alu_overflow,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_overflow,
   output logic [TAG_W-1:0]  o_rsp_tag,
   output logic [CNT_W-1:0]  o_ovf_count,
   output logic              o_proto_err
);

   localparam int unsigned CMD_W = INST_W + 2 * DATA_W + TAG_W;
   localparam int unsigned RSP_W = DATA_W + 1 + TAG_W;

   logic             cmd_push;
   logic             cmd_full;
   logic             cmd_empty;
   logic [CMD_W-1:0] cmd_din;
   logic [CMD_W-1:0] cmd_dout;
   logic [CMD_W-1:0] cmd_head;
   logic             issue;

   logic             rsp_push;
   logic             rsp_pop;
   logic             rsp_full;
   logic             rsp_empty;
   logic [RSP_W-1:0] rsp_din;
   logic [RSP_W-1:0] rsp_dout;
   logic [RSP_W-1:0] rsp_head;
   logic [1:0]       rsp_occ;

   logic [TAG_W-1:0] tag_ctr;
   logic [TAG_W-1:0] head_tag;
   logic [TAG_W-1:0] inflight_tag;
   logic             inflight;

   assign o_cmd_ready = !i_rst && !cmd_full;
   assign cmd_push    = i_cmd_valid && o_cmd_ready;
   assign cmd_din     = {i_cmd_inst, i_cmd_a, i_cmd_b, tag_ctr};

   alu_issuer_sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (cmd_push),
      .din   (cmd_din),
      .pop   (issue),
      .dout  (cmd_dout),
      .full  (cmd_full),
      .empty (cmd_empty)
   );

   assign cmd_head = cmd_empty ? '0 : cmd_dout;
   assign {o_alu_inst, o_alu_data_a, o_alu_data_b, head_tag} = cmd_head;

   // Never let results in flight plus queued responses exceed the 2 slots.
   assign rsp_pop     = o_rsp_valid && i_rsp_ready;
   assign rsp_occ     = rsp_full ? 2'd2 : (rsp_empty ? 2'd0 : 2'd1);
   assign issue       = !cmd_empty &&
                        ((3'(rsp_occ) + 3'(inflight)) < (3'd2 + 3'(rsp_pop)));
   assign o_alu_valid = issue;

   assign rsp_push = inflight;
   assign rsp_din  = {i_alu_data, i_alu_overflow, inflight_tag};

   alu_issuer_sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (2)
   ) u_rsp_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (rsp_push),
      .din   (rsp_din),
      .pop   (rsp_pop),
      .dout  (rsp_dout),
      .full  (rsp_full),
      .empty (rsp_empty)
   );

   assign o_rsp_valid = !rsp_empty;
   assign rsp_head    = rsp_empty ? '0 : rsp_dout;
   assign {o_rsp_data, o_rsp_overflow, o_rsp_tag} = rsp_head;

   // Tagging, in-flight tracking, overflow count and protocol check.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tag_ctr      <= '0;
         inflight     <= 1'b0;
         inflight_tag <= '0;
         o_ovf_count  <= '0;
         o_proto_err  <= 1'b0;
      end else begin
         if (cmd_push) tag_ctr <= tag_ctr + TAG_W'(1);
         inflight <= issue;
         if (issue) inflight_tag <= head_tag;
         if (inflight && !i_alu_valid) o_proto_err <= 1'b1;
         if (inflight && i_alu_overflow && (o_ovf_count != '1))
            o_ovf_count <= o_ovf_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: 1-cycle ALU model plus an in-order response
// scoreboard checked every cycle, and directed scenarios with literals.
module tb_alu_issuer;
   import alu_issuer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_inst;
   logic [7:0] cmd_a, cmd_b;
   logic       alu_valid;
   logic [2:0] alu_inst;
   logic [7:0] alu_a, alu_b;
   logic       alu_ok, alu_ovf;
   logic [7:0] alu_res;
   logic       rsp_valid, rsp_ready, rsp_ovf;
   logic [7:0] rsp_data;
   logic [3:0] rsp_tag;
   logic [7:0] ovf_count;
   logic       proto_err;
   logic       drop_valid;

   int checks = 0;
   int errors = 0;

   logic [12:0] exp_q[$];
   logic [12:0] e;
   logic [7:0]  got_data[$];
   logic        got_ovf[$];
   logic [3:0]  got_tag[$];
   int model_tag, model_ovf, issued, returned;
   int cyc, first_issue, last_issue, issue_cnt;
   bit proto_armed;

   logic [2:0] s_op[8] = '{OP_MUL, OP_SUB, OP_MIN, OP_OR, OP_XOR, OP_RELU, OP_MEAN, OP_ADD};
   logic [7:0] s_a[8]  = '{8'h20, 8'h10, 8'h40, 8'h0F, 8'h55, 8'hE0, 8'h30, 8'h7F};
   logic [7:0] s_b[8]  = '{8'h30, 8'h30, 8'hC0, 8'hF0, 8'h0F, 8'h10, 8'h10, 8'h01};

   always #5 clk = ~clk;

   alu_issuer dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_cmd_valid    (cmd_valid),
      .o_cmd_ready    (cmd_ready),
      .i_cmd_inst     (cmd_inst),
      .i_cmd_a        (cmd_a),
      .i_cmd_b        (cmd_b),
      .o_alu_valid    (alu_valid),
      .o_alu_inst     (alu_inst),
      .o_alu_data_a   (alu_a),
      .o_alu_data_b   (alu_b),
      .i_alu_valid    (alu_ok),
      .i_alu_data     (alu_res),
      .i_alu_overflow (alu_ovf),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_data     (rsp_data),
      .o_rsp_overflow (rsp_ovf),
      .o_rsp_tag      (rsp_tag),
      .o_ovf_count    (ovf_count),
      .o_proto_err    (proto_err)
   );

   // Q3.5 ALU result: {overflow, data}, wrapping on overflow.
   function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      int sa, sb, r;
      logic [7:0] d;
      logic v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r = 0;
      case (op)
         OP_ADD:  r = sa + sb;
         OP_SUB:  r = sa - sb;
         OP_MUL:  r = (sa * sb) >>> 5;
         OP_RELU: r = (sa < 0) ? 0 : sa;
         OP_MEAN: r = (sa + sb) >>> 1;
         OP_MIN:  r = (sa < sb) ? sa : sb;
         default: r = 0;
      endcase
      if (op == OP_OR) begin
         d = a | b; v = 1'b0;
      end else if (op == OP_XOR) begin
         d = a ^ b; v = 1'b0;
      end else begin
         d = 8'(r); v = (r > 127) || (r < -128);
      end
      return {v, d};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_ok <= 1'b0; alu_res <= '0; alu_ovf <= 1'b0;
      end else begin
         alu_ok <= !drop_valid;
         {alu_ovf, alu_res} <= alu_fn(alu_inst, alu_a, alu_b);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Scoreboard: every accepted command must come back once, in order.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back({alu_fn(cmd_inst, cmd_a, cmd_b), 4'(model_tag)});
            model_tag = (model_tag + 1) % 16;
         end
         if (alu_valid) begin
            if (issue_cnt == 0) first_issue = cyc;
            last_issue = cyc;
            issue_cnt++;
            issued++;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) chk("stale_rsp", 1, 0);
            else begin
               e = exp_q[0];
               chk("rsp_data", int'(rsp_data), int'(e[11:4]));
               chk("rsp_ovf", int'(rsp_ovf), int'(e[12]));
               chk("rsp_tag", int'(rsp_tag), int'(e[3:0]));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  returned++;
                  got_data.push_back(rsp_data);
                  got_ovf.push_back(rsp_ovf);
                  got_tag.push_back(rsp_tag);
                  if (e[12] && model_ovf < 255) model_ovf++;
               end
            end
         end
         chk("outstanding_le_2", (issued - returned <= 2) ? 1 : 0, 1);
         if (exp_q.size() == 0) chk("ovf_count", int'(ovf_count), model_ovf);
         if (!proto_armed) chk("proto_err_clear", int'(proto_err), 0);
      end
   end

   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      cmd_valid = 1'b1; cmd_inst = op; cmd_a = a; cmd_b = b;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin n++; @(negedge clk); end
      if (!cmd_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || rsp_valid) && n < 400) begin @(negedge clk); n++; end
      chk("drain_done", (exp_q.size() == 0) ? 1 : 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_zero();
      chk("rst_alu_valid", int'(alu_valid), 0);
      chk("rst_alu_inst", int'(alu_inst), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      chk("rst_rsp_ovf", int'(rsp_ovf), 0);
      chk("rst_rsp_tag", int'(rsp_tag), 0);
      chk("rst_ovf_count", int'(ovf_count), 0);
      chk("rst_proto_err", int'(proto_err), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_zero();
      cmd_valid = 1'b0;
      exp_q.delete(); got_data.delete(); got_ovf.delete(); got_tag.delete();
      model_tag = 0; model_ovf = 0; issued = 0; returned = 0; issue_cnt = 0;
      proto_armed = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cmd_valid = 1'b0; cmd_inst = '0; cmd_a = '0; cmd_b = '0;
      rsp_ready = 1'b1; drop_valid = 1'b0; proto_armed = 1'b0;
      model_tag = 0; model_ovf = 0; issued = 0; returned = 0;
      cyc = 0; first_issue = 0; last_issue = 0; issue_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      check_zero();
      rst = 1'b0;

      // Single ADD 1.0 + 1.0
      send(OP_ADD, 8'h20, 8'h20);
      @(negedge clk);
      chk("issue_latency", int'(alu_valid), 1);
      @(posedge clk); #1;
      drain();
      chk("add_data", int'(got_data[0]), 8'h40);
      chk("add_ovf", int'(got_ovf[0]), 0);
      chk("add_tag", int'(got_tag[0]), 0);

      // 3.0 + 3.0 overflows
      got_data.delete(); got_ovf.delete(); got_tag.delete();
      send(OP_ADD, 8'h60, 8'h60);
      drain();
      chk("ovf_data", int'(got_data[0]), 8'hC0);
      chk("ovf_flag", int'(got_ovf[0]), 1);
      chk("ovf_tag", int'(got_tag[0]), 1);
      chk("ovf_count_1", int'(ovf_count), 1);

      // Back-to-back stream of 8
      do_reset();
      for (int i = 0; i < 8; i++) send(s_op[i], s_a[i], s_b[i]);
      drain();
      chk("stream_issues", issue_cnt, 8);
      chk("stream_span", last_issue - first_issue, 7);
      chk("stream_mul", int'(got_data[0]), 8'h30);
      chk("stream_sub", int'(got_data[1]), 8'hE0);
      chk("stream_min", int'(got_data[2]), 8'hC0);
      chk("stream_add_ovf", int'(got_ovf[7]), 1);
      for (int i = 0; i < 8; i++) chk("stream_tag", int'(got_tag[i]), i);

      // Backpressure: 6 commands with rsp_ready low
      rsp_ready = 1'b0;
      issue_cnt = 0;
      got_data.delete(); got_ovf.delete(); got_tag.delete();
      for (int i = 0; i < 6; i++) send(OP_ADD, 8'(i), 8'(i));
      repeat (4) @(negedge clk);
      chk("bp_issues", issue_cnt, 2);
      chk("bp_cmd_ready", int'(cmd_ready), 0);
      chk("bp_alu_valid", int'(alu_valid), 0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();
      chk("bp_count", got_tag.size(), 6);
      for (int i = 0; i < 6; i++) chk("bp_tag", int'(got_tag[i]), (8 + i) % 16);

      // Reset with an op in flight
      for (int i = 0; i < 3; i++) send(OP_ADD, 8'h01, 8'h02);
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      send(OP_ADD, 8'h08, 8'h08);
      drain();
      chk("post_rst_count", got_tag.size(), 1);
      chk("post_rst_tag", int'(got_tag[0]), 0);
      chk("post_rst_data", int'(got_data[0]), 8'h10);

      // Overflow counter saturation
      for (int i = 0; i < 260; i++) send(OP_ADD, 8'h60, 8'h60);
      drain();
      chk("ovf_saturated", int'(ovf_count), 255);

      // Protocol error on a capture with i_alu_valid low
      proto_armed = 1'b1;
      drop_valid = 1'b1;
      got_data.delete(); got_ovf.delete(); got_tag.delete();
      send(OP_ADD, 8'h10, 8'h10);
      drain();
      drop_valid = 1'b0;
      chk("proto_set", int'(proto_err), 1);
      chk("proto_data_kept", int'(got_data[0]), 8'h20);
      repeat (5) @(posedge clk);
      #1;
      chk("proto_sticky", int'(proto_err), 1);
      do_reset();
      repeat (2) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Initiator/scheduler that drives the fixed-point ALU (Q3.5 default) and collects its results.
- Accepts commands (inst, a, b) from a host over a valid/ready stream and buffers them in a small FIFO.
- Issues at most one command per cycle to the ALU, captures the registered ALU result one cycle later, and returns it to the host as a tagged response stream.
- Keeps a saturating count of overflowed results.

Parameters:
- INT_W, 3, integer bits of operands/results.
- FRAC_W, 5, fraction bits.
- INST_W, 3, opcode width.
- DATA_W, INT_W+FRAC_W, operand/result width.
- CMD_DEPTH, 4, command FIFO entries (power of two, >=2).
- TAG_W, 4, response tag width.
- CNT_W, 8, overflow counter width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_cmd_valid  input  1  host command valid.
- o_cmd_ready  output  1  command FIFO not full.
- i_cmd_inst  input  INST_W  opcode.
- i_cmd_a  input  DATA_W  operand a (signed).
- i_cmd_b  input  DATA_W  operand b (signed).
- o_alu_valid  output  1  issue strobe to ALU i_valid.
- o_alu_inst  output  INST_W  to ALU i_inst.
- o_alu_data_a  output  DATA_W  to ALU i_data_a.
- o_alu_data_b  output  DATA_W  to ALU i_data_b.
- i_alu_valid  input  1  ALU o_valid.
- i_alu_data  input  DATA_W  ALU o_data.
- i_alu_overflow  input  1  ALU o_overflow.
- o_rsp_valid  output  1  response available.
- i_rsp_ready  input  1  host accepts response.
- o_rsp_data  output  DATA_W  result.
- o_rsp_overflow  output  1  result overflow flag.
- o_rsp_tag  output  TAG_W  tag of originating command.
- o_ovf_count  output  CNT_W  saturating overflow count.
- o_proto_err  output  1  sticky: i_alu_valid low when a result was expected.

Behaviour:
- Reset (async, i_rst=1): all outputs 0; FIFOs empty; tag counter 0; in-flight bit 0; o_proto_err 0. Any command in flight is dropped; the ALU output in the cycle after reset is ignored.
- Command accept: when i_cmd_valid && o_cmd_ready. The entry gets tag = tag counter, which then increments mod 2^TAG_W. o_cmd_ready = !cmd_full.
- Issue condition: cmd FIFO non-empty AND (rsp_count + inflight - rsp_pop) < 2, where rsp_pop = o_rsp_valid && i_rsp_ready.
- On issue: the ALU-side outputs are driven combinationally from the FIFO head with o_alu_valid=1, and the FIFO pops. Otherwise o_alu_valid=0, and inst/a/b hold the head value (or 0 if empty).
- Issue registers inflight=1 and the tag.
- ALU latency is fixed at 1 cycle. The ALU raises o_valid every cycle after reset, so i_alu_valid is NOT used to detect results.
- Capture: in the cycle after an issue (inflight=1), sample i_alu_data, i_alu_overflow and the in-flight tag into the response FIFO. If i_alu_valid=0 at that moment, set o_proto_err (sticky until reset); the data is still captured.
- Response FIFO: 2 entries. o_rsp_* show the head. o_rsp_valid = non-empty, and it is held stable until accepted.
- Throughput: 1 command/cycle when i_rsp_ready is held high.
- Overflow counter: increments on each capture with overflow=1 and saturates at 2^CNT_W-1.
- Simultaneous events:
  - Cmd push and issue pop in the same cycle: both happen, even when the FIFO is full.
  - Rsp push and rsp pop in the same cycle: both happen.
- Order: responses are returned strictly in command order. No reordering; no drop except on reset.

Decomposition:
- Shared package holds: opcode localparams (ADD=0, SUB=1, MUL=2, OR=3, XOR=4, RELU=5, MEAN=6, MIN=7) and default width constants.
- One natural sub-module: sync_fifo (parameterised width/depth, full/empty, simultaneous push/pop). It is instantiated for the command FIFO (width INST_W+2*DATA_W+TAG_W) and for the response FIFO (width DATA_W+1+TAG_W, depth 2).

Test Plan:
- Single ADD, a=0x20, b=0x20, i_rsp_ready=1:
  - o_alu_valid in the accept+1 cycle.
  - rsp data=0x40, overflow=0, tag=0, valid two cycles after issue... i.e. the cycle after capture.
- ADD a=0x60, b=0x60 (3.0+3.0) -> data=0xC0, overflow=1, o_ovf_count=1.
- Back-to-back stream of 8 commands (MUL 0x20*0x30, SUB, MIN, ...) with rsp_ready=1:
  - one issue per cycle.
  - tags 0..7 in order.
  - MUL gives 0x30.
- i_rsp_ready=0 with 6 commands pushed:
  - exactly 2 issues occur, then o_alu_valid stays 0.
  - cmd FIFO fills to 4 and o_cmd_ready=0.
  - releasing ready drains all 6 in order with none lost.
- Assert i_rst mid-stream, with an in-flight op:
  - all outputs 0 immediately (asynchronous).
  - after release, the next command gets tag 0 and no stale response appears.
- Overflow saturation and protocol error:
  - with CNT_W=2, four overflowing ADDs -> count stays 3.
  - force i_alu_valid=0 on a capture cycle -> o_proto_err=1, and it holds until reset.
